// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8-bit UART transmitter with a programmable divisor,
// optional parity and one or two stop bits.
// One byte is accepted at a time from IDLE. The frame is start, 8 data bits
// LSB first, an optional parity bit, then STOP_BITS stop bits.
// Each bit lasts D = max(baud_div, 1) clocks. The divisor is captured when the
// byte is accepted.
module uart_tx_ctrl #(
  parameter int PRESCALER_WIDTH = 8,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PRESCALER_WIDTH-1:0] baud_div,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       tx_done
);

  localparam int PW = PRESCALER_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] cnt;       // cycle within the current bit, 0..D-1
  logic [PW-1:0] div_q;     // divisor captured at accept
  logic [2:0]    bit_idx;   // data bit being sent; wraps to 0 after bit 7
  logic [7:0]    data_q;    // byte captured at accept
  logic          stop_idx;  // which stop bit is on the line (0 or 1)

  logic [PW-1:0] d_eff;
  logic          bit_last;
  logic          par_bit;
  logic          accept;

  // A divisor of zero behaves like one, so the frame never stalls.
  assign d_eff    = (div_q == '0) ? PW'(1) : div_q;
  assign bit_last = (cnt == d_eff - PW'(1));

  // XOR of the data gives even parity; inverting it gives odd parity.
  assign par_bit  = (^data_q) ^ (PARITY_ODD != 0);

  // in_ready comes straight from the state register. It is gated by reset so
  // that nothing can be accepted in a cycle where reset is asserted.
  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // Frame sequencer. tx, busy and tx_done are all registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (accept) begin
            data_q   <= in_data;
            div_q    <= baud_div;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_last) begin
            cnt   <= '0;
            tx    <= data_q[0];
            state <= DATA;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end

        DATA: begin
          if (bit_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + PW'(1);
          end
        end

        PARITY: begin
          if (bit_last) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end

        STOP: begin
          if (bit_last) begin
            cnt <= '0;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              // tx_done is raised in the first IDLE cycle. A new byte can be
              // accepted in that same cycle.
              stop_idx <= 1'b0;
              busy     <= 1'b0;
              tx_done  <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + PW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl. Four instances cover the parameter corners:
//   0: no parity, 1 stop
//   1: even parity, 1 stop
//   2: odd parity, 1 stop
//   3: no parity, 2 stops
// The expected tx waveform is built as a list of frame bits, and each bit is
// repeated D times.
module tb_uart_tx_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] baud_div;
  logic [7:0] in_data;
  logic [3:0] vld;
  wire  [3:0] rdy_w, tx_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  int acc_cnt [4];

  always #5 clock = ~clock;

  uart_tx_ctrl #(.PRESCALER_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .baud_div(baud_div), .in_data(in_data), .in_valid(vld[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_ctrl #(.PRESCALER_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clock(clock), .reset(reset), .baud_div(baud_div), .in_data(in_data), .in_valid(vld[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_ctrl #(.PRESCALER_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clock(clock), .reset(reset), .baud_div(baud_div), .in_data(in_data), .in_valid(vld[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_ctrl #(.PRESCALER_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clock(clock), .reset(reset), .baud_div(baud_div), .in_data(in_data), .in_valid(vld[3]),
    .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  // Count handshakes per instance, sampled at the edge where they take effect.
  initial for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
  always @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (vld[i] === 1'b1 && rdy_w[i] === 1'b1) acc_cnt[i]++;

  function automatic int cfg_pe(input int i);   return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_odd(input int i);  return (i == 2) ? 1 : 0;           endfunction
  function automatic int cfg_sb(input int i);   return (i == 3) ? 2 : 1;           endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Entered in the first cycle after the accept edge. Returns in the tx_done cycle.
  task automatic check_frame(input int i, input logic [7:0] b, input int div, input string tag);
    bit bits[$];
    bit exp_q[$];
    int d;
    d = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (cfg_pe(i) != 0) bits.push_back((^b) ^ (cfg_odd(i) != 0));
    for (int k = 0; k < cfg_sb(i); k++) bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < d; r++) exp_q.push_back(bits[k]);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (tx_w[i] !== exp_q[k] || busy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                 tag, i, k, tx_w[i], busy_w[i], done_w[i], exp_q[k]);
      end
      step();
    end
    checks++;
    if ({tx_w[i], busy_w[i], done_w[i], rdy_w[i]} !== 4'b1011) begin
      errors++;
      $display("FAIL %s_done inst%0d: tx/busy/done/ready=%b%b%b%b, expected 1011",
               tag, i, tx_w[i], busy_w[i], done_w[i], rdy_w[i]);
    end
  endtask

  // Offer one byte to instance i. After the accept the divisor input is
  // scrambled to show that the frame uses the captured value.
  task automatic send(input int i, input logic [7:0] b, input int div, input string tag);
    in_data  = b;
    baud_div = 8'(div);
    vld[i]   = 1'b1;
    checks++;
    if (rdy_w[i] !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready inst%0d: in_ready=%b, expected 1", tag, i, rdy_w[i]);
    end
    step();
    vld[i]   = 1'b0;
    baud_div = 8'($urandom);
    check_frame(i, b, div, tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; vld = 4'hF; in_data = 8'h5A; baud_div = 8'd3;
    step();
    checks++;
    if (rdy_w !== 4'h0 || tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%h tx=%h busy=%h done=%h, expected 0 f 0 0", rdy_w, tx_w, busy_w, done_w);
    end
    step();
    checks++;
    if (busy_w !== 4'h0 || tx_w !== 4'hF) begin
      errors++;
      $display("FAIL reset_no_accept: busy=%h tx=%h, expected 0 f", busy_w, tx_w);
    end
    vld = 4'h0; reset = 1'b0;
    #1;
    checks++;
    if (rdy_w !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_ready: ready=%h, expected f", rdy_w);
    end
  endtask

  task automatic test_basic();
    send(0, 8'hA5, 4, "a5_div4");
  endtask

  task automatic test_div_zero_one();
    send(0, 8'h00, 0, "div0");
    send(0, 8'h00, 1, "div1");
  endtask

  task automatic test_parity();
    for (int i = 1; i <= 2; i++) begin
      send(i, 8'h07, 2, "par07");
      send(i, 8'h03, 2, "par03");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int i;
      i = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) step();
      send(i, 8'($urandom), $urandom_range(0, 6), "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [3];
    int a0;
    for (int k = 0; k < 3; k++) q[k] = 8'($urandom);
    a0 = acc_cnt[3];
    in_data = q[0]; baud_div = 8'd3; vld[3] = 1'b1;
    step();
    in_data = q[1];
    check_frame(3, q[0], 3, "b2b0");
    step();
    in_data = q[2]; baud_div = 8'd5;
    check_frame(3, q[1], 3, "b2b1");
    step();
    vld[3] = 1'b0;
    check_frame(3, q[2], 5, "b2b2");
    repeat (3) step();
    checks++;
    if (acc_cnt[3] - a0 != 3 || busy_w[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accepts: accepts=%0d busy=%b, expected 3 and 0", acc_cnt[3] - a0, busy_w[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit saw_done;
    b = 8'($urandom);
    in_data = b; baud_div = 8'd2; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    repeat (8) step();
    checks++;
    if (tx_w[0] !== b[3] || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3: tx=%b busy=%b, expected tx=%b busy=1", tx_w[0], busy_w[0], b[3]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b ready=%b done=%b, expected 1 0 1 0",
               tx_w[0], busy_w[0], rdy_w[0], done_w[0]);
    end
    saw_done = 1'b0;
    repeat (25) begin
      step();
      if (done_w[0] !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_no_done: tx_done pulsed after abandoned frame, expected none");
    end
    send(0, 8'($urandom), 3, "after_reset");
  endtask

  initial begin
    reset = 1'b1; vld = 4'h0; in_data = 8'h00; baud_div = 8'd0;
    test_reset();
    test_basic();
    test_div_zero_one();
    test_parity();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
